operand_fetch_stage: RTL and testbench

- Operand-fetch stage directly upstream of the modified function unit.
- Holds the 8x16 general register file with one write port from writeback and two read ports.
- Selects register or constant/PC operands and registers Bus_A, Bus_B, FS and SH into a pipeline latch that drives the function unit.
- Supports stall, flush and write-to-read bypass.

---
 rtl/operand_fetch_stage.sv | 78 +++++++
 tb/tb_operand_fetch_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: 8x16 register file with write-to-read bypass, operand
// muxes and the pipeline latch that feeds the function unit.
module operand_fetch_stage #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [AW-1:0]    AA,
    input  logic [AW-1:0]    BA,
    input  logic             MA,
    input  logic             MB,
    input  logic [WIDTH-1:0] PC_1,
    input  logic [WIDTH-1:0] CONST_in,
    input  logic [4:0]       FS_in,
    input  logic [4:0]       SH_in,
    input  logic             RW,
    input  logic [AW-1:0]    DA,
    input  logic [WIDTH-1:0] D_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] Bus_A,
    output logic [WIDTH-1:0] Bus_B,
    output logic [4:0]       FS1,
    output logic [4:0]       SH1,
    output logic             out_valid
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // Writes land regardless of stall/flush; only reset blocks them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RW) begin
            regs[DA] <= D_in;
        end
    end

    // Same-cycle writeback is forwarded so fetch never sees a stale value.
    always_comb begin
        rd_a = regs[AA];
        rd_b = regs[BA];
        if (RW && (DA == AA)) begin
            rd_a = D_in;
        end
        if (RW && (DA == BA)) begin
            rd_b = D_in;
        end
        op_a = MA ? PC_1     : rd_a;
        op_b = MB ? CONST_in : rd_b;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            Bus_A     <= '0;
            Bus_B     <= '0;
            FS1       <= '0;
            SH1       <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            Bus_A     <= op_a;
            Bus_B     <= op_b;
            FS1       <= FS_in;
            SH1       <= SH_in;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomized and directed checking of operand_fetch_stage against a
// transaction-level model of the register file and pipeline latch.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [2:0]  AA, BA, DA;
    logic        MA, MB, RW, stall, flush;
    logic [15:0] PC_1, CONST_in, D_in;
    logic [4:0]  FS_in, SH_in;
    logic [15:0] Bus_A, Bus_B;
    logic [4:0]  FS1, SH1;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_regs [8];
    logic [15:0] e_a, e_b;
    logic [4:0]  e_fs, e_sh;
    logic        e_v;

    operand_fetch_stage #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .AA(AA), .BA(BA), .MA(MA), .MB(MB),
        .PC_1(PC_1), .CONST_in(CONST_in), .FS_in(FS_in), .SH_in(SH_in),
        .RW(RW), .DA(DA), .D_in(D_in), .stall(stall), .flush(flush),
        .Bus_A(Bus_A), .Bus_B(Bus_B), .FS1(FS1), .SH1(SH1), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model, then compare every latch output.
    task automatic cycle();
        logic [15:0] view [8];
        view = m_regs;
        if (!reset_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            {e_a, e_b, e_fs, e_sh, e_v} = '0;
        end else begin
            // Reading after the write has been applied is what the bypass guarantees.
            if (RW) view[DA] = D_in;
            if (flush) begin
                {e_a, e_b, e_fs, e_sh, e_v} = '0;
            end else if (!stall) begin
                e_a  = MA ? PC_1 : view[AA];
                e_b  = MB ? CONST_in : view[BA];
                e_fs = FS_in;
                e_sh = SH_in;
                e_v  = in_valid;
            end
            m_regs = view;
        end
        @(posedge clk);
        #1;
        check_val("Bus_A", 32'(Bus_A), 32'(e_a));
        check_val("Bus_B", 32'(Bus_B), 32'(e_b));
        check_val("FS1", 32'(FS1), 32'(e_fs));
        check_val("SH1", 32'(SH1), 32'(e_sh));
        check_val("out_valid", 32'(out_valid), 32'(e_v));
    endtask

    task automatic idle();
        reset_n = 1'b1; in_valid = 1'b0; AA = '0; BA = '0; DA = '0;
        MA = 1'b0; MB = 1'b0; RW = 1'b0; stall = 1'b0; flush = 1'b0;
        PC_1 = '0; CONST_in = '0; D_in = '0; FS_in = '0; SH_in = '0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        idle(); RW = 1'b1; DA = a; D_in = d;
        cycle();
    endtask

    task automatic fetch(input logic [2:0] a, input logic [2:0] b);
        idle(); in_valid = 1'b1; AA = a; BA = b; FS_in = 5'h02;
        cycle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        cycle();
        cycle();

        // Reset clears a previously written register and the latch.
        write_reg(3'd3, 16'h1234);
        fetch(3'd3, 3'd3);
        check_val("pre_reset_r3", 32'(Bus_A), 32'h1234);
        idle(); reset_n = 1'b0; RW = 1'b1; DA = 3'd5; D_in = 16'h5555; stall = 1'b1;
        cycle();
        check_val("reset_valid", 32'(out_valid), 32'h0);
        fetch(3'd3, 3'd5);
        check_val("reset_r3", 32'(Bus_A), 32'h0000);
        check_val("reset_r5", 32'(Bus_B), 32'h0000);

        // Basic fetch.
        write_reg(3'd1, 16'h00A5);
        write_reg(3'd2, 16'h5A00);
        fetch(3'd1, 3'd2);
        check_val("basic_a", 32'(Bus_A), 32'h00A5);
        check_val("basic_b", 32'(Bus_B), 32'h5A00);
        check_val("basic_fs", 32'(FS1), 32'h02);

        // Same-cycle bypass.
        idle(); RW = 1'b1; DA = 3'd4; D_in = 16'hBEEF; AA = 3'd4; BA = 3'd4; in_valid = 1'b1;
        cycle();
        check_val("bypass_a", 32'(Bus_A), 32'hBEEF);
        check_val("bypass_b", 32'(Bus_B), 32'hBEEF);

        // Operand muxes.
        idle(); in_valid = 1'b1; AA = 3'd1; BA = 3'd2; MA = 1'b1; MB = 1'b1;
        PC_1 = 16'h0010; CONST_in = 16'h0007;
        cycle();
        check_val("mux_a", 32'(Bus_A), 32'h0010);
        check_val("mux_b", 32'(Bus_B), 32'h0007);

        // Stall holds the latch while the register file still accepts writes.
        fetch(3'd1, 3'd1);
        for (int i = 0; i < 3; i++) begin
            idle(); stall = 1'b1; in_valid = 1'b1; AA = 3'd2; BA = 3'd2;
            if (i == 0) begin RW = 1'b1; DA = 3'd1; D_in = 16'hFFFF; end
            cycle();
            check_val("stall_hold_a", 32'(Bus_A), 32'h00A5);
            check_val("stall_hold_v", 32'(out_valid), 32'h1);
        end
        idle(); stall = 1'b1; flush = 1'b1; in_valid = 1'b1;
        cycle();
        check_val("flush_v", 32'(out_valid), 32'h0);
        check_val("flush_a", 32'(Bus_A), 32'h0);
        fetch(3'd1, 3'd0);
        check_val("after_stall_r1", 32'(Bus_A), 32'hFFFF);

        // Back-to-back reads of every register.
        for (int i = 0; i < 8; i++) write_reg(3'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            fetch(3'(i), 3'(7 - i));
            check_val("b2b_a", 32'(Bus_A), 32'h1000 + 32'(i));
            check_val("b2b_v", 32'(out_valid), 32'h1);
        end

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            reset_n  = ($urandom_range(0, 63) != 0);
            in_valid = 1'($urandom);
            AA = 3'($urandom); BA = 3'($urandom); DA = 3'($urandom);
            MA = ($urandom_range(0, 3) == 0); MB = ($urandom_range(0, 3) == 0);
            RW = 1'($urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            PC_1 = 16'($urandom); CONST_in = 16'($urandom); D_in = 16'($urandom);
            FS_in = 5'($urandom); SH_in = 5'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
